// File: rtl/dram_pkg.sv
// Shared types for the DRAM request arbiter.
package dram_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/dram_req_arbiter_rr_picker.sv
// Combinational requester picker: round-robin from ptr by default,
// fixed lowest-index priority when DRAM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            vld
);
`ifdef DRAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDW'(k);
      end
    end
  end
`else
  always_comb begin
    logic [IDW-1:0] j;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    // Walk the ring starting at ptr; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = IDW'((int'(ptr) + k) % NREQ);
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
`endif
endmodule

// File: rtl/dram_req_arbiter.sv
// Arbitrates NREQ requesters onto the single DRAM command FSM port.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module dram_req_arbiter
  import dram_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_done,
  output logic [DATA_W-1:0]      req_rdata,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   dREN,
  output logic                   dWEN,
  output logic [ADDR_W-1:0]      daddr,
  output logic [DATA_W-1:0]      dwdata,
  input  logic [DATA_W-1:0]      drdata,
  input  logic                   ram_wait,
  input  logic                   init_done,
  input  logic                   rf_req
);
  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [IDW-1:0]    ptr_q, ptr_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [IDW-1:0]    pick_idx;
  logic              pick_vld;

  rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (req_ren | req_wen),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: if (pick_vld && init_done && !rf_req) begin
        state_d = ISSUE;
        gid_d   = pick_idx;
        // Write takes precedence when a requester raises both.
        wr_d    = |(pick_gnt & req_wen);
        addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
        wdata_d = req_wdata[pick_idx*DATA_W +: DATA_W];
`ifndef DRAM_ARB_FIXED_PRIO_EN
        ptr_d   = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
`endif
      end
      ISSUE: if (ram_wait) state_d = BUSY;
      BUSY: if (!ram_wait) begin
        state_d = DONE;
        rdata_d = drdata;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      gid_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ptr_q   <= ptr_d;
    end
  end

  logic cmd_act;
  assign cmd_act   = (state_q == ISSUE) || (state_q == BUSY);
  assign dREN      = cmd_act && !wr_q;
  assign dWEN      = cmd_act && wr_q;
  assign busy      = (state_q != IDLE);
  assign req_done  = (state_q == DONE) ? (NREQ'(1) << gid_q) : '0;
  assign req_rdata = rdata_q;
  assign grant_id  = gid_q;
  assign daddr     = addr_q;
  assign dwdata    = wdata_q;
endmodule

// File: tb/tb_dram_req_arbiter.sv
// Randomized self-checking bench for dram_req_arbiter against a
// behavioural pick-order model.
module tb_dram_req_arbiter;
  localparam int NREQ = 4, ADDR_W = 32, DATA_W = 32, IDW = 2;

  logic                   CLK = 0, nRST = 0;
  logic [NREQ-1:0]        req_ren = '0, req_wen = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ-1:0]        req_done;
  logic [DATA_W-1:0]      req_rdata, drdata = '0;
  logic [IDW-1:0]         grant_id;
  logic                   busy, dREN, dWEN, ram_wait = 0, init_done = 0, rf_req = 0;
  logic [ADDR_W-1:0]      daddr;
  logic [DATA_W-1:0]      dwdata;

  dram_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDW(IDW)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .req_rdata(req_rdata), .grant_id(grant_id), .busy(busy), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dwdata(dwdata), .drdata(drdata),
    .ram_wait(ram_wait), .init_done(init_done), .rf_req(rf_req));

  always #5 CLK = ~CLK;

  int vec = 0, err = 0;
  int m_ptr = 0;

  typedef struct {
    bit timeout; int lat; int gid; bit wr; bit rd; bit both; bit held; bit busy_ok;
    bit cmd_in_done; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wd;
    logic [NREQ-1:0] done; logic [NREQ-1:0] done_after; logic [DATA_W-1:0] rdata;
  } obs_t;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Model of who should win: scan the ring from the last winner + 1,
  // or lowest index in the fixed-priority build.
  function automatic int ref_pick(input logic [NREQ-1:0] r);
`ifdef DRAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic void ref_grant(input int w);
    m_ptr = (w + 1) % NREQ;
  endfunction

  // Plays the command FSM for one transaction; records what was seen.
  task automatic serve(input int n_issue, input int nbusy, input logic [DATA_W-1:0] rd,
                       input bit drop, input bit rf_busy, output obs_t o);
    o.timeout = 0; o.lat = 0; o.gid = -1; o.wr = 0; o.rd = 0; o.both = 0; o.held = 1;
    o.busy_ok = 0; o.cmd_in_done = 0; o.addr = '0; o.wd = '0; o.done = '0;
    o.done_after = '0; o.rdata = '0;
    while (!(dREN || dWEN) && o.lat < 40) begin tick(); o.lat++; end
    if (!(dREN || dWEN)) begin o.timeout = 1; return; end
    o.gid = int'(grant_id); o.wr = dWEN; o.rd = dREN; o.addr = daddr; o.wd = dwdata;
    o.busy_ok = busy; o.both = dREN && dWEN;
    repeat (n_issue) begin
      o.held &= (dREN == o.rd) && (dWEN == o.wr) && busy && (req_done == '0);
      tick();
    end
    ram_wait = 1;
    for (int i = 0; i < nbusy; i++) begin
      o.held &= (dREN == o.rd) && (dWEN == o.wr) && busy && (req_done == '0);
      o.both |= dREN && dWEN;
      tick();
      if (i == 0) begin
        if (drop) begin req_ren = '0; req_wen = '0; end
        if (rf_busy) rf_req = 1;
      end
    end
    o.held &= (dREN == o.rd) && (dWEN == o.wr) && busy && (req_done == '0);
    drdata = rd; ram_wait = 0;
    tick();
    o.done = req_done; o.rdata = req_rdata; o.cmd_in_done = dREN || dWEN;
    drdata = $urandom;
    tick();
    o.done_after = req_done;
  endtask

  task automatic do_reset();
    nRST = 0; req_ren = '0; req_wen = '0; ram_wait = 0; rf_req = 0; init_done = 0;
    repeat (2) tick();
    nRST = 1; m_ptr = 0;
    tick();
  endtask

  task automatic test_reset();
    nRST = 0; #3;
    if ({dREN, dWEN, busy, req_done, grant_id, req_rdata, daddr, dwdata} !== '0) begin
      $display("FAIL reset_outputs got dREN=%b dWEN=%b busy=%b done=%b gid=%0d rdata=%h addr=%h wd=%h want all 0",
               dREN, dWEN, busy, req_done, grant_id, req_rdata, daddr, dwdata);
      err++;
    end
    vec++;
    do_reset();
  endtask

  task automatic test_single_read();
    obs_t o;
    init_done = 1;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h100;
    req_ren = 4'b0010;
    serve(1, 2, 32'hDEAD, 0, 0, o);
    req_ren = '0;
    ref_grant(1);
    if (o.timeout || o.lat != 1) begin $display("FAIL read_latency got %0d want 1", o.lat); err++; end
    vec++;
    if (o.gid != 1 || !o.rd || o.wr) begin
      $display("FAIL read_grant got gid=%0d rd=%b wr=%b want gid=1 rd=1 wr=0", o.gid, o.rd, o.wr); err++;
    end
    vec++;
    if (o.addr !== 32'h100 || !o.busy_ok || !o.held) begin
      $display("FAIL read_cmd got addr=%h busy=%b held=%b want 100 1 1", o.addr, o.busy_ok, o.held); err++;
    end
    vec++;
    if (o.done !== 4'b0010 || o.rdata !== 32'hDEAD || o.cmd_in_done) begin
      $display("FAIL read_done got done=%b rdata=%h cmd=%b want 0010 dead 0", o.done, o.rdata, o.cmd_in_done); err++;
    end
    vec++;
    if (o.done_after !== '0) begin $display("FAIL read_pulse_width got %b want 0000", o.done_after); err++; end
    vec++;
  endtask

  task automatic test_round_robin();
    obs_t o;
    int cnt[NREQ];
    int w;
    logic [DATA_W-1:0] rd;
    do_reset(); init_done = 1;
    foreach (cnt[i]) cnt[i] = 0;
    req_ren = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      w = ref_pick(req_ren);
      rd = $urandom;
      serve($urandom_range(0, 2), $urandom_range(1, 3), rd, 0, 0, o);
      ref_grant(w);
      if (o.timeout || o.lat != 1 || o.gid != w) begin
        $display("FAIL rr_order[%0d] got gid=%0d lat=%0d want gid=%0d lat=1", t, o.gid, o.lat, w); err++;
      end
      vec++;
      if (o.done !== (4'b1 << w) || o.rdata !== rd) begin
        $display("FAIL rr_done[%0d] got done=%b rdata=%h want %b %h", t, o.done, o.rdata, 4'b1 << w, rd); err++;
      end
      vec++;
      for (int i = 0; i < NREQ; i++) if (o.done[i]) cnt[i]++;
    end
    req_ren = '0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (cnt[i] != 2) begin $display("FAIL rr_fairness[%0d] got %0d want 2", i, cnt[i]); err++; end
      vec++;
    end
`endif
  endtask

  task automatic test_gating();
    obs_t o;
    bit bad = 0;
    int w;
    init_done = 0; req_ren = 4'b1000;
    repeat (5) begin tick(); bad |= dREN || dWEN || busy; end
    if (bad) begin $display("FAIL gate_init got cmd activity=1 want 0"); err++; end
    vec++;
    init_done = 1;
    w = ref_pick(req_ren);
    serve(0, 1, 32'h1, 0, 0, o);
    req_ren = '0; ref_grant(w);
    if (o.timeout || o.lat != 1 || o.gid != w) begin
      $display("FAIL gate_release got gid=%0d lat=%0d want gid=%0d lat=1", o.gid, o.lat, w); err++;
    end
    vec++;
    req_ren = 4'b0011;
    w = ref_pick(req_ren);
    serve(0, 2, 32'h2, 0, 1, o);
    ref_grant(w);
    if (o.timeout || o.done !== (4'b1 << w)) begin
      $display("FAIL rf_inflight got done=%b want %b", o.done, 4'b1 << w); err++;
    end
    vec++;
    bad = 0;
    repeat (4) begin tick(); bad |= dREN || dWEN || busy; end
    if (bad) begin $display("FAIL rf_block got cmd activity=1 want 0"); err++; end
    vec++;
    rf_req = 0;
    w = ref_pick(req_ren);
    serve(0, 1, 32'h3, 0, 0, o);
    req_ren = '0; ref_grant(w);
    if (o.timeout || o.lat != 1 || o.gid != w) begin
      $display("FAIL rf_release got gid=%0d lat=%0d want gid=%0d lat=1", o.gid, o.lat, w); err++;
    end
    vec++;
  endtask

  task automatic test_conflict_drop();
    obs_t o;
    req_wdata[2*DATA_W +: DATA_W] = 32'h55;
    req_addr[2*ADDR_W +: ADDR_W] = 32'hA0;
    req_ren = 4'b0100; req_wen = 4'b0100;
    serve(0, 3, 32'h77, 1, 0, o);
    ref_grant(2);
    if (o.timeout || !o.wr || o.rd || o.both || o.wd !== 32'h55) begin
      $display("FAIL conflict got wr=%b rd=%b both=%b wd=%h want 1 0 0 55", o.wr, o.rd, o.both, o.wd); err++;
    end
    vec++;
    if (!o.held || o.done !== 4'b0100) begin
      $display("FAIL drop_complete got held=%b done=%b want 1 0100", o.held, o.done); err++;
    end
    vec++;
  endtask

  task automatic test_random();
    obs_t o;
    int w;
    bit exp_wr;
    logic [DATA_W-1:0] rd;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_addr[i*ADDR_W +: ADDR_W] = $urandom;
        req_wdata[i*DATA_W +: DATA_W] = $urandom;
      end
      req_ren = NREQ'($urandom_range(0, 15));
      req_wen = NREQ'($urandom_range(0, 15));
      if ((req_ren | req_wen) == '0) req_ren = NREQ'(1) << $urandom_range(0, NREQ-1);
      w = ref_pick(req_ren | req_wen);
      exp_wr = req_wen[w];
      rd = $urandom;
      serve($urandom_range(0, 2), $urandom_range(1, 4), rd, bit'($urandom_range(0, 1)), 0, o);
      ref_grant(w);
      if (o.timeout || o.gid != w || o.wr != exp_wr || o.rd == exp_wr || o.both) begin
        $display("FAIL rand_grant[%0d] got gid=%0d wr=%b rd=%b want gid=%0d wr=%b", t, o.gid, o.wr, o.rd, w, exp_wr); err++;
      end
      vec++;
      if (o.addr !== req_addr[w*ADDR_W +: ADDR_W] || (exp_wr && o.wd !== req_wdata[w*DATA_W +: DATA_W])) begin
        $display("FAIL rand_payload[%0d] got addr=%h wd=%h want %h %h", t, o.addr, o.wd,
                 req_addr[w*ADDR_W +: ADDR_W], req_wdata[w*DATA_W +: DATA_W]); err++;
      end
      vec++;
      if (o.done !== (4'b1 << w) || o.done_after !== '0 || !o.held || (!exp_wr && o.rdata !== rd)) begin
        $display("FAIL rand_done[%0d] got done=%b after=%b held=%b rdata=%h want %b 0000 1 %h",
                 t, o.done, o.done_after, o.held, o.rdata, 4'b1 << w, rd); err++;
      end
      vec++;
      req_ren = '0; req_wen = '0;
    end
  endtask

  task automatic test_reset_midop();
    obs_t o;
    int n = 0;
    req_ren = 4'b0100;
    while (!dREN && n < 40) begin tick(); n++; end
    ram_wait = 1;
    tick(); tick();
    #2 nRST = 0; #1;
    if (n >= 40 || dREN || dWEN || busy || req_done !== '0) begin
      $display("FAIL reset_midop got dREN=%b dWEN=%b busy=%b done=%b want all 0", dREN, dWEN, busy, req_done); err++;
    end
    vec++;
    tick();
    nRST = 1; ram_wait = 0; m_ptr = 0; req_ren = 4'b1111;
    serve(0, 1, 32'h9, 0, 0, o);
    req_ren = '0; ref_grant(0);
    if (o.timeout || o.gid != 0) begin $display("FAIL reset_ptr got gid=%0d want 0", o.gid); err++; end
    vec++;
  endtask

  task automatic test_two_held();
    obs_t o;
    int w;
    req_ren = 4'b1001;
    for (int t = 0; t < 4; t++) begin
      w = ref_pick(req_ren);
      serve(0, 1, $urandom, 0, 0, o);
      ref_grant(w);
      if (o.timeout || o.gid != w) begin
        $display("FAIL two_held[%0d] got gid=%0d want %0d", t, o.gid, w); err++;
      end
      vec++;
    end
    req_ren = '0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_gating();
    test_conflict_drop();
    test_random();
    test_reset_midop();
    test_two_held();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got stuck want finish");
    $fatal(1);
  end
endmodule
